// File: rtl/div19s8s.sv
// Iterative signed divider: 19-bit dividend / 8-bit divisor -> 11-bit quotient, 8-bit remainder.
// Sign-magnitude restoring division, one quotient bit per cycle, valid/ready on both sides.
module div19s8s (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [18:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] quotient,
  output logic [7:0]  remainder,
  output logic        ovf,
  output logic        dz
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [18:0] dvd_q, dvd_d;
  logic [7:0]  dvs_q, dvs_d;
  logic        sgn_dvd_q, sgn_dvd_d;
  logic        sgn_dvs_q, sgn_dvs_d;
  logic        zero_q, zero_d;
  logic [8:0]  prem_q, prem_d;
  logic [18:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [10:0] quotient_q, quotient_d;
  logic [7:0]  remainder_q, remainder_d;
  logic        ovf_q, ovf_d;
  logic        dz_q, dz_d;

  logic [9:0]  shifted;
  logic [9:0]  trial;
  logic        neg;

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    sgn_dvd_d   = sgn_dvd_q;
    sgn_dvs_d   = sgn_dvs_q;
    zero_d      = zero_q;
    prem_d      = prem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;

    // prem never exceeds 127, so bit 9 of the trial is a reliable borrow flag
    shifted = {prem_q, dvd_q[18]};
    trial   = shifted - {2'b00, dvs_q};
    neg     = sgn_dvd_q ^ sgn_dvs_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d     = dividend[18] ? -dividend : dividend;
          dvs_d     = divisor[7] ? -divisor : divisor;
          sgn_dvd_d = dividend[18];
          sgn_dvs_d = divisor[7];
          zero_d    = (divisor == '0);
          prem_d    = '0;
          quo_d     = '0;
          cnt_d     = 5'd18;
          state_d   = CALC;
        end
      end
      CALC: begin
        dvd_d = {dvd_q[17:0], 1'b0};
        if (!trial[9]) begin
          prem_d = trial[8:0];
          quo_d  = {quo_q[17:0], 1'b1};
        end else begin
          prem_d = shifted[8:0];
          quo_d  = {quo_q[17:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      FIX: begin
        ovf_d = 1'b0;
        dz_d  = 1'b0;
        if (zero_q) begin
          quotient_d  = sgn_dvd_q ? 11'h400 : 11'h3FF;
          remainder_d = '0;
          dz_d        = 1'b1;
        end else if (!neg && (quo_q > 19'd1023)) begin
          quotient_d  = 11'h3FF;
          remainder_d = '0;
          ovf_d       = 1'b1;
        end else if (neg && (quo_q > 19'd1024)) begin
          quotient_d  = 11'h400;
          remainder_d = '0;
          ovf_d       = 1'b1;
        end else begin
          quotient_d  = neg ? -quo_q[10:0] : quo_q[10:0];
          remainder_d = sgn_dvd_q ? -prem_q[7:0] : prem_q[7:0];
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      sgn_dvd_q   <= 1'b0;
      sgn_dvs_q   <= 1'b0;
      zero_q      <= 1'b0;
      prem_q      <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      sgn_dvd_q   <= sgn_dvd_d;
      sgn_dvs_q   <= sgn_dvs_d;
      zero_q      <= zero_d;
      prem_q      <= prem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

// File: doc/div19s8s.md
Name: div19s8s

Overview:
- Iterative signed divider: 19-bit signed dividend by 8-bit signed divisor, producing an 11-bit signed quotient and an 8-bit signed remainder.
- Inverse of the 11s x 8s pipelined multiplier: feeding a multiplier product and its 8-bit operand back through this block recovers the 11-bit operand.
- Works in sign-magnitude, like the multiplier: magnitudes go through unsigned restoring division (one quotient bit per cycle), then the signs are applied.
- Valid/ready handshake on both the input and output sides.

Parameters:
- None. All widths are fixed: dividend 19, divisor 8, quotient 11, remainder 8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- dividend  input  19  signed two's-complement dividend
- divisor  input  8  signed two's-complement divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  11  signed quotient, truncated toward zero
- remainder  output  8  signed remainder; takes the dividend's sign
- ovf  output  1  quotient saturated because the true quotient does not fit
- dz  output  1  divide by zero

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; in_ready=1; out_valid=0.
  - quotient, remainder, ovf, dz all 0.
  - Any in-flight operation is discarded.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register |dividend| (19-bit unsigned, so -262144 gives 262144), |divisor| (8-bit unsigned, so -128 gives 128), the sign of dividend, the sign of divisor, and divisor==0.
  - Clear the partial remainder (9 bits) and the quotient shift register (19 bits).
  - Bit counter=18; go to CALC.
- CALC, one iteration per cycle:
  - trial = {prem, next dividend bit, MSB first} - |divisor|.
  - If the trial is non-negative: prem=trial, shift in 1. Otherwise keep the shifted prem and shift in 0.
  - Exactly 19 cycles; at count 0 go to FIX.
  - Divide-by-zero still runs all 19 cycles, so latency is constant.
- FIX, one cycle, precedence in this order:
  - dz set: quotient = 1023 if dividend>=0, else -1024; remainder=0; dz=1; ovf=0.
  - Quotient sign = sign(dividend) XOR sign(divisor).
  - Positive result with magnitude >1023, or negative result with magnitude >1024: saturate to 1023 or -1024; remainder=0; ovf=1.
  - Otherwise: apply the sign to the quotient magnitude. Apply the dividend's sign to the remainder magnitude (always <=127).
  - A zero quotient or zero remainder is always +0; no negative zero is produced.
  - Go to DONE.
- DONE:
  - out_valid=1; outputs held stable until out_ready.
  - On out_valid&out_ready: go to IDLE, out_valid=0.
  - in_ready=0 in CALC, FIX and DONE. There is one bubble cycle between ops: a new accept can occur no earlier than the cycle after the output handshake.
- Latency: accept at edge k gives out_valid high after edge k+20.
- in_valid during busy states is ignored, and the operands are not sampled.
- dividend/divisor are sampled only at the accept edge; later changes have no effect.
- Arithmetic identity when ovf=dz=0: dividend = quotient*divisor + remainder, with |remainder| < |divisor|.

Test Plan:
- Basic signs:
  - 1000/7 -> q=142, r=6.
  - -1000/7 -> q=-142, r=-6.
  - 1000/-7 -> q=-142, r=6.
  - -1000/-7 -> q=142, r=-6.
  - In every case out_valid rises exactly 20 cycles after the accept.
- Boundaries:
  - -130048/127 -> q=-1024, r=0, ovf=0.
  - 130048/127 -> ovf=1, q=1023 (true q is 1024).
  - 262143/1 -> ovf=1, q=1023, r=0.
  - -262144/-128 -> ovf=1, q=1023.
  - 0/-5 -> q=0, r=0, no flags.
- Divide by zero:
  - 500/0 -> dz=1, q=1023, r=0, ovf=0.
  - -5/0 -> dz=1, q=-1024.
  - Latency is still 20 cycles.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid; keep in_valid=1 with new operands throughout.
  - Required: outputs stable, in_ready=0, no accept.
  - Release out_ready: out_valid falls next edge, in_ready=1, the new op is accepted the following cycle and produces the correct result.
- Reset mid-operation:
  - Assert rst_n=0 for one edge, 10 cycles into CALC.
  - Required: next cycle state IDLE, in_ready=1, out_valid=0, all outputs 0.
  - A subsequent 77/-3 -> q=-25, r=2.
- Random regression:
  - 10k random operand pairs with random out_ready stalls.
  - Checked against a reference model: truncating division, saturation and flag rules as above.
